// File: rtl/pad_link_pkg.sv
// Shared definitions for controller-pad link receivers: frame layout,
// receiver states and the frame checksum helper.
package pad_link_pkg;

    localparam logic [7:0]  HEADER     = 8'hA5;
    localparam int unsigned FRAME_BITS = 32;
    localparam logic [7:0]  CHK_XOR    = 8'hFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RX   = 1'b1
    } rx_state_e;

    // Received frame, first byte on the wire in the top byte.
    typedef struct packed {
        logic [7:0] header;
        logic [7:0] data_hi;
        logic [7:0] data_lo;
        logic [7:0] chk;
    } pad_frame_t;

    // Checksum the sender places in the last byte of a frame.
    function automatic logic [7:0] pad_chk(input logic [7:0] hi, input logic [7:0] lo);
        return hi ^ lo ^ CHK_XOR;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for one asynchronous input, followed by a history
// flop. level, rise and fall are all registered and mutually aligned, so a
// data line sampled with level lines up with a clock line's rise pulse.
module sync_edge (
    input  logic system_clock,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;

    // Synchronise, keep one cycle of history and register the edge pulses.
    always_ff @(posedge system_clock) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            level  <= sync_q;
            rise   <= sync_q & ~level;
            fall   <= ~sync_q & level;
        end
    end

endmodule

// File: rtl/spi_pad_rx.sv
// Mode-0 SPI slave receiving 32-bit controller button frames. A frame is
// checked on chip-select release and, if good, its button word is
// presented atomically; the word falls back to all-released on link loss.
module spi_pad_rx
    import pad_link_pkg::*;
#(
    parameter int unsigned BITS           = 12,
    parameter logic [7:0]  HEADER         = pad_link_pkg::HEADER,
    parameter int unsigned TIMEOUT_CYCLES = 2400000
) (
    input  logic            system_clock,
    input  logic            reset_n,
    input  logic            spi_sck,
    input  logic            spi_mosi,
    input  logic            spi_cs_n,
    output logic [BITS-1:0] buttons,
    output logic            frame_ok,
    output logic            frame_err,
    output logic            link_up
);

    localparam int unsigned CNT_W   = 6;
    localparam int unsigned TMO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(FRAME_BITS + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic sck_rise;
    logic sck_level;
    logic sck_fall;
    logic mosi_level;
    logic mosi_rise;
    logic mosi_fall;
    logic cs_level;
    logic cs_rise;
    logic cs_fall;

    rx_state_e        state_q,   state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [31:0]      shift_q,   shift_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [BITS-1:0]  buttons_d;
    logic             frame_ok_d;
    logic             frame_err_d;
    logic             link_up_d;

    pad_frame_t       frame;
    logic [15:0]      frame_data;
    logic             frame_good;
    logic             unused_sync;

    sync_edge u_sync_sck (
        .system_clock (system_clock),
        .reset_n      (reset_n),
        .din          (spi_sck),
        .level        (sck_level),
        .rise         (sck_rise),
        .fall         (sck_fall)
    );

    sync_edge u_sync_mosi (
        .system_clock (system_clock),
        .reset_n      (reset_n),
        .din          (spi_mosi),
        .level        (mosi_level),
        .rise         (mosi_rise),
        .fall         (mosi_fall)
    );

    sync_edge u_sync_cs (
        .system_clock (system_clock),
        .reset_n      (reset_n),
        .din          (spi_cs_n),
        .level        (cs_level),
        .rise         (cs_rise),
        .fall         (cs_fall)
    );

    // Only the SCK rise, MOSI level and CS edges matter to the receiver.
    assign unused_sync = ^{sck_level, sck_fall, mosi_rise, mosi_fall, cs_level};

    // Frame check against the shift register as it stands at CS release.
    assign frame      = pad_frame_t'(shift_q);
    assign frame_data = {frame.data_hi, frame.data_lo};
    assign frame_good = (bit_cnt_q == CNT_FULL) &&
                        (frame.header == HEADER) &&
                        (frame.chk == pad_chk(frame.data_hi, frame.data_lo));

    // State and output registers.
    always_ff @(posedge system_clock) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tmo_cnt_q <= '0;
            buttons   <= '1;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            link_up   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tmo_cnt_q <= tmo_cnt_d;
            buttons   <= buttons_d;
            frame_ok  <= frame_ok_d;
            frame_err <= frame_err_d;
            link_up   <= link_up_d;
        end
    end

    // Next state: link timeout first, then frame commit overrides it.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tmo_cnt_d   = tmo_cnt_q;
        buttons_d   = buttons;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        link_up_d   = link_up;

        if (link_up) begin
            if (tmo_cnt_q == TMO_LAST) begin
                buttons_d = '1;
                link_up_d = 1'b0;
                tmo_cnt_d = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
        end else begin
            tmo_cnt_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_RX;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            ST_RX: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    if (frame_good) begin
                        buttons_d  = frame_data[BITS-1:0];
                        frame_ok_d = 1'b1;
                        link_up_d  = 1'b1;
                        tmo_cnt_d  = '0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else if (sck_rise) begin
                    shift_d = {shift_q[30:0], mosi_level};
                    if (bit_cnt_q != CNT_OVF) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_pad_rx.sv
// Directed bench for spi_pad_rx: frame acceptance/rejection, commit latency,
// link timeout, reset mid-frame and back-to-back frames.
`timescale 1ns/1ps
module tb_spi_pad_rx;

    localparam int unsigned BITS  = 12;
    localparam int unsigned TMO   = 100;
    localparam int          H_NOM = 6;   // half SCK period in clocks: 4 MHz at 48 MHz
    localparam int          GAP   = 96;  // about 2 us of CS high at 48 MHz

    logic            system_clock = 1'b0;
    logic            reset_n      = 1'b0;
    logic            spi_sck      = 1'b0;
    logic            spi_mosi     = 1'b0;
    logic            spi_cs_n     = 1'b1;
    logic [BITS-1:0] buttons;
    logic            frame_ok;
    logic            frame_err;
    logic            link_up;

    int checks  = 0;
    int fails   = 0;
    int ok_cnt  = 0;
    int err_cnt = 0;
    int mix_cnt = 0;
    bit watch_mix = 1'b0;

    spi_pad_rx #(
        .BITS           (BITS),
        .HEADER         (8'hA5),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .system_clock (system_clock),
        .reset_n      (reset_n),
        .spi_sck      (spi_sck),
        .spi_mosi     (spi_mosi),
        .spi_cs_n     (spi_cs_n),
        .buttons      (buttons),
        .frame_ok     (frame_ok),
        .frame_err    (frame_err),
        .link_up      (link_up)
    );

    always #10.417 system_clock = ~system_clock;

    // Pulse counters and the legal-value watch for the back-to-back run.
    always @(negedge system_clock) begin
        if (frame_ok === 1'b1)  ok_cnt++;
        if (frame_err === 1'b1) err_cnt++;
        if (watch_mix && !(buttons inside {12'hFFF, 12'hF0F, 12'h5A0, 12'hA5F})) mix_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge system_clock);
    endtask

    task automatic cs_low(input int h);
        @(negedge system_clock);
        spi_cs_n = 1'b0;
        tick(h);
    endtask

    task automatic spi_bit(input logic b, input int h);
        spi_mosi = b;
        tick(h);
        spi_sck = 1'b1;
        tick(h);
        spi_sck = 1'b0;
    endtask

    task automatic cs_high(input int h);
        tick(h);
        spi_cs_n = 1'b1;
    endtask

    // Whole frame, MSB first, right-aligned in data; returns just after CS rises.
    task automatic send(input logic [39:0] data, input int nbits, input int h);
        cs_low(h);
        for (int i = nbits - 1; i >= 0; i--) spi_bit(data[i], h);
        cs_high(h);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(5);
        checks++; if (buttons !== 12'hFFF) begin fails++; $display("FAIL reset_buttons: got %h want fff", buttons); end
        checks++; if (frame_ok !== 1'b0)   begin fails++; $display("FAIL reset_frame_ok: got %b want 0", frame_ok); end
        checks++; if (frame_err !== 1'b0)  begin fails++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        checks++; if (link_up !== 1'b0)    begin fails++; $display("FAIL reset_link_up: got %b want 0", link_up); end
        reset_n = 1'b1;
        tick(5);
    endtask

    task automatic test_valid_frame();
        int ok0, err0;
        ok0 = ok_cnt; err0 = err_cnt;
        send(40'h00A5FFFEFE, 32, H_NOM);
        tick(3);
        checks++; if (frame_ok !== 1'b0)  begin fails++; $display("FAIL valid_early_ok: got %b want 0", frame_ok); end
        checks++; if (buttons !== 12'hFFF) begin fails++; $display("FAIL valid_early_buttons: got %h want fff", buttons); end
        tick(1);
        checks++; if (frame_ok !== 1'b1)  begin fails++; $display("FAIL valid_ok_pulse: got %b want 1", frame_ok); end
        checks++; if (buttons !== 12'hFFE) begin fails++; $display("FAIL valid_buttons: got %h want ffe", buttons); end
        checks++; if (link_up !== 1'b1)   begin fails++; $display("FAIL valid_link_up: got %b want 1", link_up); end
        tick(1);
        checks++; if (frame_ok !== 1'b0)  begin fails++; $display("FAIL valid_ok_width: got %b want 0", frame_ok); end
        tick(2);
        checks++; if (ok_cnt - ok0 != 1 || err_cnt - err0 != 0)
            begin fails++; $display("FAIL valid_pulse_count: got ok=%0d err=%0d want ok=1 err=0", ok_cnt - ok0, err_cnt - err0); end
    endtask

    task automatic test_bad_checksum();
        int ok0, err0;
        ok0 = ok_cnt; err0 = err_cnt;
        send(40'h00A5123400, 32, H_NOM);
        tick(4);
        checks++; if (frame_err !== 1'b1) begin fails++; $display("FAIL badchk_err_pulse: got %b want 1", frame_err); end
        checks++; if (frame_ok !== 1'b0)  begin fails++; $display("FAIL badchk_no_ok: got %b want 0", frame_ok); end
        checks++; if (buttons !== 12'hFFF) begin fails++; $display("FAIL badchk_buttons: got %h want fff", buttons); end
        tick(3);
        checks++; if (ok_cnt - ok0 != 0 || err_cnt - err0 != 1)
            begin fails++; $display("FAIL badchk_pulse_count: got ok=%0d err=%0d want ok=0 err=1", ok_cnt - ok0, err_cnt - err0); end
        checks++; if (link_up !== 1'b0)   begin fails++; $display("FAIL badchk_link_up: got %b want 0", link_up); end
    endtask

    task automatic test_short_long();
        int ok0, err0;
        ok0 = ok_cnt; err0 = err_cnt;
        send(40'h0000A50000, 24, H_NOM);
        tick(4);
        checks++; if (frame_err !== 1'b1) begin fails++; $display("FAIL short_err_pulse: got %b want 1", frame_err); end
        tick(3);
        send(40'hA5FFFEFE55, 40, H_NOM);
        tick(4);
        checks++; if (frame_err !== 1'b1) begin fails++; $display("FAIL long_err_pulse: got %b want 1", frame_err); end
        checks++; if (frame_ok !== 1'b0)  begin fails++; $display("FAIL long_no_ok: got %b want 0", frame_ok); end
        tick(3);
        checks++; if (ok_cnt - ok0 != 0 || err_cnt - err0 != 2)
            begin fails++; $display("FAIL shortlong_pulse_count: got ok=%0d err=%0d want ok=0 err=2", ok_cnt - ok0, err_cnt - err0); end
        checks++; if (buttons !== 12'hFFF) begin fails++; $display("FAIL shortlong_buttons: got %h want fff", buttons); end
    endtask

    task automatic test_timeout();
        send(40'h00A5000FF0, 32, H_NOM);
        tick(4);
        checks++; if (frame_ok !== 1'b1 || buttons !== 12'h00F)
            begin fails++; $display("FAIL tmo_commit: got ok=%b buttons=%h want ok=1 buttons=00f", frame_ok, buttons); end
        tick(99);
        checks++; if (link_up !== 1'b1 || buttons !== 12'h00F)
            begin fails++; $display("FAIL tmo_before_expiry: got link=%b buttons=%h want link=1 buttons=00f", link_up, buttons); end
        tick(1);
        checks++; if (link_up !== 1'b0 || buttons !== 12'hFFF)
            begin fails++; $display("FAIL tmo_expiry: got link=%b buttons=%h want link=0 buttons=fff", link_up, buttons); end
        checks++; if (frame_ok !== 1'b0 || frame_err !== 1'b0)
            begin fails++; $display("FAIL tmo_no_pulse: got ok=%b err=%b want 0 0", frame_ok, frame_err); end

        // Commit landing on the expiry cycle; a short frame needs a fast SCK to fit.
        send(40'h00A50A5AAF, 32, H_NOM);
        tick(4);
        checks++; if (frame_ok !== 1'b1 || buttons !== 12'hA5A)
            begin fails++; $display("FAIL tmo2_first_commit: got ok=%b buttons=%h want ok=1 buttons=a5a", frame_ok, buttons); end
        tick(29);
        send(40'h00A50B6C98, 32, 1);
        tick(3);
        checks++; if (link_up !== 1'b1 || buttons !== 12'hA5A)
            begin fails++; $display("FAIL tmo2_pre_edge: got link=%b buttons=%h want link=1 buttons=a5a", link_up, buttons); end
        tick(1);
        checks++; if (frame_ok !== 1'b1) begin fails++; $display("FAIL tmo2_ok_on_expiry: got %b want 1", frame_ok); end
        checks++; if (link_up !== 1'b1 || buttons !== 12'hB6C)
            begin fails++; $display("FAIL tmo2_commit_wins: got link=%b buttons=%h want link=1 buttons=b6c", link_up, buttons); end
        tick(99);
        checks++; if (link_up !== 1'b1 || buttons !== 12'hB6C)
            begin fails++; $display("FAIL tmo2_counter_cleared: got link=%b buttons=%h want link=1 buttons=b6c", link_up, buttons); end
        tick(1);
        checks++; if (link_up !== 1'b0 || buttons !== 12'hFFF)
            begin fails++; $display("FAIL tmo2_second_expiry: got link=%b buttons=%h want link=0 buttons=fff", link_up, buttons); end
    endtask

    task automatic test_reset_mid_frame();
        int ok0, err0;
        logic [31:0] f;
        f = 32'hA5FFFEFE;
        ok0 = ok_cnt; err0 = err_cnt;
        cs_low(H_NOM);
        for (int i = 31; i >= 15; i--) spi_bit(f[i], H_NOM);
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        for (int i = 14; i >= 0; i--) spi_bit(f[i], H_NOM);
        cs_high(H_NOM);
        tick(8);
        checks++; if (ok_cnt - ok0 != 0 || err_cnt - err0 != 0)
            begin fails++; $display("FAIL rstmid_no_pulse: got ok=%0d err=%0d want 0 0", ok_cnt - ok0, err_cnt - err0); end
        checks++; if (buttons !== 12'hFFF) begin fails++; $display("FAIL rstmid_buttons: got %h want fff", buttons); end
        checks++; if (link_up !== 1'b0)    begin fails++; $display("FAIL rstmid_link_up: got %b want 0", link_up); end
        send(40'h00A51234D9, 32, H_NOM);
        tick(4);
        checks++; if (frame_ok !== 1'b1 || buttons !== 12'h234 || link_up !== 1'b1)
            begin fails++; $display("FAIL rstmid_next_frame: got ok=%b buttons=%h link=%b want 1 234 1", frame_ok, buttons, link_up); end
        tick(100);
        checks++; if (buttons !== 12'hFFF || link_up !== 1'b0)
            begin fails++; $display("FAIL rstmid_timeout: got buttons=%h link=%b want fff 0", buttons, link_up); end
    endtask

    task automatic test_back_to_back();
        logic [39:0] frames [3];
        logic [11:0] want   [3];
        int ok0;
        frames[0] = 40'h00A50F0FFF; want[0] = 12'hF0F;
        frames[1] = 40'h00A505A05A; want[1] = 12'h5A0;
        frames[2] = 40'h00A50A5FAA; want[2] = 12'hA5F;
        ok0 = ok_cnt;
        mix_cnt = 0;
        watch_mix = 1'b1;
        for (int n = 0; n < 3; n++) begin
            send(frames[n], 32, H_NOM);
            tick(4);
            checks++; if (frame_ok !== 1'b1 || buttons !== want[n])
                begin fails++; $display("FAIL b2b_commit_%0d: got ok=%b buttons=%h want ok=1 buttons=%h", n, frame_ok, buttons, want[n]); end
            tick(GAP - 4);
        end
        watch_mix = 1'b0;
        checks++; if (ok_cnt - ok0 != 3) begin fails++; $display("FAIL b2b_ok_count: got %0d want 3", ok_cnt - ok0); end
        checks++; if (mix_cnt != 0)      begin fails++; $display("FAIL b2b_no_mix: got %0d illegal words want 0", mix_cnt); end
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_bad_checksum();
        test_short_long();
        test_timeout();
        test_reset_mid_frame();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
